// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the multi-channel iterative multiplier:
//   state_t     - controller FSM states (IDLE, MUL, STORE, DONE)
//   calc_steps  - engine cycles needed per channel
//   sat_hi      - largest representable result (signed or unsigned)
//   sat_lo      - smallest representable result (signed or unsigned)
// The saturation helpers return 64-bit patterns; callers keep the low
// C_WIDTH bits.
// -----------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of shift-add iterations to consume the whole multiplier
  function automatic int calc_steps(input int w, input int bpc);
    return w / bpc;
  endfunction

  // Upper clamp value: 2^(w-1)-1 when signed, 2^w-1 when unsigned
  function automatic logic [63:0] sat_hi(input int w, input bit sgn);
    if (sgn) return (64'd1 << (w - 1)) - 64'd1;
    else     return (64'd1 << w) - 64'd1;
  endfunction

  // Lower clamp value: -2^(w-1) (two's complement) when signed, 0 when unsigned
  function automatic logic [63:0] sat_lo(input int w, input bit sgn);
    if (sgn) return {64{1'b1}} << (w - 1);
    else     return 64'd0;
  endfunction

endpackage

// File: rtl/multiplier_mc_if.sv
// -----------------------------------------------------------------------------
// multiplier_mc_if
// Handshake and operand/result bus of multiplier_mc.
//   trigger - start request (master -> slave)
//   a, b    - packed operands, channel i at [i*C_WIDTH +: C_WIDTH]
//   y       - packed registered results, same packing
//   ovf     - per-channel overflow flags
//   ready   - slave idle and able to accept trigger
//   done    - one-cycle pulse when y/ovf are updated
// -----------------------------------------------------------------------------
interface multiplier_mc_if #(
  parameter int C_WIDTH = 16,
  parameter int NUM_CH  = 4
);

  logic                        trigger;
  logic [NUM_CH*C_WIDTH-1:0]   a;
  logic [NUM_CH*C_WIDTH-1:0]   b;
  logic [NUM_CH*C_WIDTH-1:0]   y;
  logic [NUM_CH-1:0]           ovf;
  logic                        ready;
  logic                        done;

  modport master (output trigger, a, b, input y, ovf, ready, done);
  modport slave  (input trigger, a, b, output y, ovf, ready, done);

endinterface

// File: rtl/mul_core.sv
// -----------------------------------------------------------------------------
// mul_core
// Single-channel iterative shift-add multiplier engine working on unsigned
// magnitudes. A load resets the accumulator and captures the operands; the
// engine then consumes BITS_PER_CYCLE multiplier bits per cycle until all
// C_WIDTH bits are used.
//   clk, rst      - clock, asynchronous active-high reset
//   load_i        - capture operands and restart (takes priority over stepping)
//   mcand_i       - multiplicand magnitude
//   mplier_i      - multiplier magnitude
//   neg_i         - product sign captured alongside the operands
//   product_o     - 2*C_WIDTH unsigned product magnitude
//   neg_o         - captured product sign
//   step_done_o   - high during the final iteration; product valid next cycle
// -----------------------------------------------------------------------------
module mul_core #(
  parameter int C_WIDTH        = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [C_WIDTH-1:0]     mcand_i,
  input  logic [C_WIDTH-1:0]     mplier_i,
  input  logic                   neg_i,
  output logic [2*C_WIDTH-1:0]   product_o,
  output logic                   neg_o,
  output logic                   step_done_o
);
  import mul_pkg::*;

  localparam int STEPS = calc_steps(C_WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int PW    = 2 * C_WIDTH;

  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      mcand_q;
  logic [C_WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [PW-1:0]      partial;

  // Partial product of the shifted multiplicand and the next multiplier digit
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // Engine registers: the multiplicand walks left and the multiplier walks
  // right so the same low digit is examined every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{C_WIDTH{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      cnt_q    <= CNT_W'(STEPS);
      neg_q    <= neg_i;
    end else if (cnt_q != '0) begin
      acc_q    <= acc_q + partial;
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  assign product_o   = acc_q;
  assign neg_o       = neg_q;
  assign step_done_o = (cnt_q == CNT_W'(1)) && !load_i;

endmodule

// File: rtl/multiplier_mc.sv
// -----------------------------------------------------------------------------
// multiplier_mc
// Multi-channel time-multiplexed fixed-point multiplier. One trigger captures
// NUM_CH operand pairs; each channel is run through the shared mul_core, then
// sign-corrected, shifted by FIXED_POINT, range-checked and stored. All
// results are published together with a single done pulse.
//   ctl_clk - clock, rising edge
//   reset   - asynchronous active-high reset
//   bus     - slave side of multiplier_mc_if (trigger, a, b, y, ovf, ready, done)
// -----------------------------------------------------------------------------
module multiplier_mc #(
  parameter int C_WIDTH        = 16,
  parameter int FIXED_POINT    = 0,
  parameter int NUM_CH         = 4,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 0,
  parameter int SATURATE       = 1
) (
  input  logic           ctl_clk,
  input  logic           reset,
  multiplier_mc_if.slave bus
);
  import mul_pkg::*;

  localparam int W   = C_WIDTH;
  localparam int PW  = 2 * C_WIDTH;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [W-1:0] HI_LIM = W'(sat_hi(W, SIGNED != 0));
  localparam logic [W-1:0] LO_LIM = W'(sat_lo(W, SIGNED != 0));

  state_t              state_q;
  logic [CHW-1:0]      ch_q;
  logic [CHW-1:0]      nextCh;
  logic                lastCh;
  logic [NUM_CH*W-1:0] a_q, b_q;
  logic [NUM_CH*W-1:0] rbuf_q, rbuf_d;
  logic [NUM_CH-1:0]   rovf_q, rovf_d;
  logic [NUM_CH*W-1:0] y_q;
  logic [NUM_CH-1:0]   ovf_q;

  logic [W-1:0]        opA, opB, magA, magB;
  logic                opNeg;
  logic                coreLoad;
  logic [PW-1:0]       coreProd;
  logic                coreNeg;
  logic                coreStepDone;

  logic [PW-1:0]       prodS, shifted;
  logic [W-1:0]        res;
  logic                resOvf;

  assign nextCh   = ch_q + CHW'(1);
  assign lastCh   = (ch_q == CHW'(NUM_CH - 1));
  assign coreLoad = ((state_q == IDLE) && bus.trigger) ||
                    ((state_q == STORE) && !lastCh);

  // Channel 0 is fed straight from the bus on the accepting edge (the copy
  // into a_q/b_q happens on that same edge); later channels come from the
  // latched operands. Signed operands become C_WIDTH-bit magnitudes, so the
  // most negative value stays exact.
  always_comb begin
    if (state_q == IDLE) begin
      opA = bus.a[W-1:0];
      opB = bus.b[W-1:0];
    end else begin
      opA = a_q[nextCh*W +: W];
      opB = b_q[nextCh*W +: W];
    end
    magA  = opA;
    magB  = opB;
    opNeg = 1'b0;
    if (SIGNED != 0) begin
      if (opA[W-1]) magA = -opA;
      if (opB[W-1]) magB = -opB;
      opNeg = opA[W-1] ^ opB[W-1];
    end
  end

  mul_core #(
    .C_WIDTH        (C_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk         (ctl_clk),
    .rst         (reset),
    .load_i      (coreLoad),
    .mcand_i     (magA),
    .mplier_i    (magB),
    .neg_i       (opNeg),
    .product_o   (coreProd),
    .neg_o       (coreNeg),
    .step_done_o (coreStepDone)
  );

  // Post-processing: restore sign, shift (arithmetic shift floors toward
  // -inf), then range-check. Signed results fit only when the top W+1 bits
  // are a pure sign extension; unsigned results need the top W bits clear.
  always_comb begin
    prodS = coreNeg ? -coreProd : coreProd;
    if (SIGNED != 0) shifted = $unsigned($signed(prodS) >>> FIXED_POINT);
    else             shifted = prodS >> FIXED_POINT;
    res    = shifted[W-1:0];
    resOvf = 1'b0;
    if (SIGNED != 0) begin
      if (shifted[PW-1:W-1] != {(W+1){shifted[PW-1]}}) begin
        resOvf = 1'b1;
        if (SATURATE != 0) res = shifted[PW-1] ? LO_LIM : HI_LIM;
      end
    end else begin
      if (shifted[PW-1:W] != '0) begin
        resOvf = 1'b1;
        if (SATURATE != 0) res = HI_LIM;
      end
    end
  end

  // Result buffer with the current channel's slot replaced
  always_comb begin
    rbuf_d = rbuf_q;
    rovf_d = rovf_q;
    rbuf_d[ch_q*W +: W] = res;
    rovf_d[ch_q]        = resOvf;
  end

  // Controller FSM. y/ovf are loaded on the edge entering DONE so they are
  // already valid during the done cycle; they are never touched otherwise.
  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rbuf_q  <= '0;
      rovf_q  <= '0;
      y_q     <= '0;
      ovf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.trigger) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            ch_q    <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (coreStepDone) state_q <= STORE;
        end
        STORE: begin
          rbuf_q <= rbuf_d;
          rovf_q <= rovf_d;
          if (lastCh) begin
            y_q     <= rbuf_d;
            ovf_q   <= rovf_d;
            state_q <= DONE;
          end else begin
            ch_q    <= nextCh;
            state_q <= MUL;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.y     = y_q;
  assign bus.ovf   = ovf_q;
  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_multiplier_mc.sv
// -----------------------------------------------------------------------------
// tb_multiplier_mc
// Self-checking bench for multiplier_mc. Five 8-bit, 2-channel instances
// cover unsigned wrap, unsigned saturate, signed Q3.4, signed integer and a
// 4-bits-per-cycle variant. A table of hand-computed vectors is run first,
// followed by handshake and mid-run reset sequences.
// -----------------------------------------------------------------------------
module tb_multiplier_mc;

  localparam int NI = 5;

  logic        clk;
  logic        reset;
  logic        trig   [NI];
  logic [15:0] aDrv   [NI];
  logic [15:0] bDrv   [NI];
  logic [15:0] yMon   [NI];
  logic [1:0]  ovfMon [NI];
  logic        rdyMon [NI];
  logic        doneMon[NI];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic [1:0]  ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  multiplier_mc_if #(.C_WIDTH(8), .NUM_CH(2)) if0 ();
  multiplier_mc_if #(.C_WIDTH(8), .NUM_CH(2)) if1 ();
  multiplier_mc_if #(.C_WIDTH(8), .NUM_CH(2)) if2 ();
  multiplier_mc_if #(.C_WIDTH(8), .NUM_CH(2)) if3 ();
  multiplier_mc_if #(.C_WIDTH(8), .NUM_CH(2)) if4 ();

  // Unsigned, wrap on overflow
  multiplier_mc #(.C_WIDTH(8), .FIXED_POINT(0), .NUM_CH(2), .BITS_PER_CYCLE(1),
                  .SIGNED(0), .SATURATE(0))
    dut0 (.ctl_clk(clk), .reset(reset), .bus(if0));
  // Unsigned, saturate
  multiplier_mc #(.C_WIDTH(8), .FIXED_POINT(0), .NUM_CH(2), .BITS_PER_CYCLE(1),
                  .SIGNED(0), .SATURATE(1))
    dut1 (.ctl_clk(clk), .reset(reset), .bus(if1));
  // Signed Q3.4, saturate
  multiplier_mc #(.C_WIDTH(8), .FIXED_POINT(4), .NUM_CH(2), .BITS_PER_CYCLE(1),
                  .SIGNED(1), .SATURATE(1))
    dut2 (.ctl_clk(clk), .reset(reset), .bus(if2));
  // Signed integer, saturate
  multiplier_mc #(.C_WIDTH(8), .FIXED_POINT(0), .NUM_CH(2), .BITS_PER_CYCLE(1),
                  .SIGNED(1), .SATURATE(1))
    dut3 (.ctl_clk(clk), .reset(reset), .bus(if3));
  // Unsigned wrap, four multiplier bits per cycle
  multiplier_mc #(.C_WIDTH(8), .FIXED_POINT(0), .NUM_CH(2), .BITS_PER_CYCLE(4),
                  .SIGNED(0), .SATURATE(0))
    dut4 (.ctl_clk(clk), .reset(reset), .bus(if4));

  assign if0.trigger = trig[0]; assign if0.a = aDrv[0]; assign if0.b = bDrv[0];
  assign if1.trigger = trig[1]; assign if1.a = aDrv[1]; assign if1.b = bDrv[1];
  assign if2.trigger = trig[2]; assign if2.a = aDrv[2]; assign if2.b = bDrv[2];
  assign if3.trigger = trig[3]; assign if3.a = aDrv[3]; assign if3.b = bDrv[3];
  assign if4.trigger = trig[4]; assign if4.a = aDrv[4]; assign if4.b = bDrv[4];

  assign yMon[0] = if0.y; assign ovfMon[0] = if0.ovf; assign rdyMon[0] = if0.ready; assign doneMon[0] = if0.done;
  assign yMon[1] = if1.y; assign ovfMon[1] = if1.ovf; assign rdyMon[1] = if1.ready; assign doneMon[1] = if1.done;
  assign yMon[2] = if2.y; assign ovfMon[2] = if2.ovf; assign rdyMon[2] = if2.ready; assign doneMon[2] = if2.done;
  assign yMon[3] = if3.y; assign ovfMon[3] = if3.ovf; assign rdyMon[3] = if3.ready; assign doneMon[3] = if3.done;
  assign yMon[4] = if4.y; assign ovfMon[4] = if4.ovf; assign rdyMon[4] = if4.ready; assign doneMon[4] = if4.done;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] y, input logic [1:0] ovf, input int lat);
    vec_t v;
    v.inst = inst; v.a = a; v.b = b; v.y = y; v.ovf = ovf; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Starts one run on instance k and counts rising edges, including the one
  // that samples trigger, until done is seen. Operands are scrambled right
  // after the sampling edge. Returns -1 if done never appears.
  task automatic applyStimulus(input int k, input logic [15:0] av, input logic [15:0] bv,
                               output int lat);
    @(negedge clk);
    aDrv[k] = av;
    bDrv[k] = bv;
    trig[k] = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    trig[k] = 1'b0;
    aDrv[k] = ~av;
    bDrv[k] = ~bv;
    while (!doneMon[k] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!doneMon[k]) lat = -1;
  endtask

  initial begin
    int lat;
    int pulses;
    int readyEarly;
    int doneEdge;
    int edges;
    logic prevDone;
    logic fell;
    logic readyAtFall;
    logic [15:0] yCap;
    logic [1:0]  ovfCap;

    // Reset asserted from time zero; outputs must be at reset values
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      trig[k] = 1'b0;
      aDrv[k] = '0;
      bDrv[k] = '0;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("reset y%0d", k),     32'(yMon[k]),    32'h0);
      checkOutput($sformatf("reset ovf%0d", k),   32'(ovfMon[k]),  32'h0);
      checkOutput($sformatf("reset ready%0d", k), 32'(rdyMon[k]),  32'h1);
      checkOutput($sformatf("reset done%0d", k),  32'(doneMon[k]), 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // inst, a {ch1,ch0}, b {ch1,ch0}, expected y, expected ovf, latency
    addVec(0, 16'h2403, 16'h7302, 16'h2C06, 2'b10, 19);
    addVec(1, 16'h2403, 16'h7302, 16'hFF06, 2'b10, 19);
    addVec(2, 16'h7F18, 16'h7FE0, 16'h7FD0, 2'b10, 19);
    addVec(3, 16'h8080, 16'h0180, 16'h807F, 2'b01, 19);
    addVec(4, 16'h2403, 16'h7302, 16'h2C06, 2'b10, 7);
    addVec(0, 16'h0000, 16'h00FF, 16'h0000, 2'b00, 19);
    addVec(0, 16'h10FF, 16'h0FFF, 16'hF001, 2'b01, 19);
    addVec(1, 16'h10FF, 16'h0FFF, 16'hF0FF, 2'b01, 19);
    addVec(2, 16'h80F0, 16'h1008, 16'h80F8, 2'b00, 19);
    addVec(2, 16'h8001, 16'h80FF, 16'h7FFF, 2'b10, 19);
    addVec(4, 16'h10FF, 16'h0FFF, 16'hF001, 2'b01, 7);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].inst, vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d y", i),   32'(yMon[vecs[i].inst]),   32'(vecs[i].y));
      checkOutput($sformatf("vec%0d ovf", i), 32'(ovfMon[vecs[i].inst]), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d ready in done", i), 32'(rdyMon[vecs[i].inst]), 32'h0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done pulse width", i), 32'(doneMon[vecs[i].inst]), 32'h0);
      checkOutput($sformatf("vec%0d ready after", i),      32'(rdyMon[vecs[i].inst]),  32'h1);
    end

    // Second trigger with other operands three edges into a run is ignored
    @(negedge clk);
    aDrv[0] = 16'h2403;
    bDrv[0] = 16'h7302;
    trig[0] = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    trig[0] = 1'b0;
    pulses = 0; readyEarly = 0; doneEdge = -1;
    prevDone = 1'b0; fell = 1'b0; readyAtFall = 1'b0;
    yCap = '0; ovfCap = '0;
    for (int e = 0; e < 45; e++) begin
      if (edges == 3) begin
        aDrv[0] = 16'h1111;
        bDrv[0] = 16'h2222;
        trig[0] = 1'b1;
      end else begin
        trig[0] = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (doneMon[0]) begin
        pulses++;
        if (doneEdge < 0) begin
          doneEdge = edges;
          yCap = yMon[0];
          ovfCap = ovfMon[0];
        end
      end
      if (prevDone && !doneMon[0] && !fell) begin
        fell = 1'b1;
        readyAtFall = rdyMon[0];
      end
      if (!fell && rdyMon[0]) readyEarly++;
      prevDone = doneMon[0];
    end
    trig[0] = 1'b0;
    checkOutput("busy done edge",      32'(doneEdge),    32'd19);
    checkOutput("busy done pulses",    32'(pulses),      32'd1);
    checkOutput("busy y",              32'(yCap),        32'h2C06);
    checkOutput("busy ovf",            32'(ovfCap),      32'h2);
    checkOutput("busy ready early",    32'(readyEarly),  32'd0);
    checkOutput("busy ready at fall",  32'(readyAtFall), 32'h1);

    // Asynchronous reset seven edges into a run, checked before any clock edge
    @(negedge clk);
    aDrv[0] = 16'h10FF;
    bDrv[0] = 16'h0FFF;
    trig[0] = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    trig[0] = 1'b0;
    while (edges < 7) begin
      @(posedge clk);
      edges++;
    end
    #1;
    checkOutput("midrun ready before reset", 32'(rdyMon[0]), 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("midrun reset y0",    32'(yMon[0]),    32'h0);
    checkOutput("midrun reset ovf0",  32'(ovfMon[0]),  32'h0);
    checkOutput("midrun reset ready", 32'(rdyMon[0]),  32'h1);
    checkOutput("midrun reset done",  32'(doneMon[0]), 32'h0);
    checkOutput("midrun reset y4",    32'(yMon[4]),    32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 16'h2403, 16'h7302, lat);
    checkOutput("post-reset latency", 32'(lat),       32'd19);
    checkOutput("post-reset y",       32'(yMon[0]),   32'h2C06);
    checkOutput("post-reset ovf",     32'(ovfMon[0]), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_mc.md
Name: multiplier_mc

Overview:
- Multi-channel, time-multiplexed iterative fixed-point multiplier; next generation of the single-channel `multiplier` block.
- Takes NUM_CH packed operand pairs on one trigger and processes them one channel at a time on a shared shift-add engine.
- Returns all products together with one done pulse.
- Adds signed mode, selectable bits-per-cycle, saturation and per-channel overflow flags; used by synth voice/envelope scaling paths.

Parameters:
- C_WIDTH, 16, operand and result width per channel.
- FIXED_POINT, 0, fractional bits; full product is shifted right by this amount (0 <= FIXED_POINT < C_WIDTH).
- NUM_CH, 4, number of channels (>= 1).
- BITS_PER_CYCLE, 1, multiplier bits consumed per engine cycle (1, 2 or 4); C_WIDTH % BITS_PER_CYCLE == 0.
- SIGNED, 0, 1 = two's-complement operands/results, 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low C_WIDTH bits).

Ports:
- ctl_clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- trigger, in, 1, start request, sampled only while ready=1.
- a, in, NUM_CH*C_WIDTH, operand A; channel i at [i*C_WIDTH +: C_WIDTH].
- b, in, NUM_CH*C_WIDTH, operand B; same packing.
- y, out, NUM_CH*C_WIDTH, registered results; same packing.
- ovf, out, NUM_CH, per-channel overflow flag, updated with y.
- ready, out, 1, high when idle and able to accept trigger.
- done, out, 1, one-cycle pulse when y/ovf are updated.

Behaviour:
- Reset values, applied asynchronously: y=0, ovf=0, ready=1, done=0, state IDLE, channel index 0, engine registers 0.
- Constant: STEPS = C_WIDTH/BITS_PER_CYCLE.
- FSM state IDLE: ready=1.
  - trigger=1 at an edge latches a and b into internal registers, sets ch=0 and moves to MUL.
  - ready drops on that edge.
- FSM state MUL: runs exactly STEPS cycles on channel ch.
  - Each cycle adds (multiplicand × next BITS_PER_CYCLE multiplier bits) to a 2*C_WIDTH accumulator.
  - Then moves to STORE.
- FSM state STORE, 1 cycle:
  - Post-processes the accumulator and writes the result into an internal result buffer slot ch.
  - If ch == NUM_CH-1, moves to DONE; otherwise ch++ and returns to MUL.
- FSM state DONE, 1 cycle:
  - Copies the buffer to y and ovf; done=1, ready=0.
  - Next edge: IDLE, done=0, ready=1.
- Latency: done is high in the cycle after exactly LAT = NUM_CH*(STEPS+1)+1 rising edges following the edge that sampled trigger.
- Busy behaviour: trigger while ready=0 is ignored, with no queuing.
  - Input changes after the sampling edge have no effect on the current run.
- Signed mode: operands are converted to magnitude (C_WIDTH-bit unsigned, so the most negative value is exact).
  - The product sign is the XOR of the operand signs.
  - The product is negated in STORE.
- Post-processing order: full 2*C_WIDTH product → arithmetic (signed) or logical shift right by FIXED_POINT (truncation toward −inf) → range check against C_WIDTH.
- Overflow: set when the shifted value is outside the signed or unsigned C_WIDTH range.
  - SATURATE=1: clamp to max/min, i.e. unsigned 2^W−1; signed 2^(W−1)−1 or −2^(W−1).
  - SATURATE=0: take the low C_WIDTH bits.
  - ovf[i] is set in both cases.
- y and ovf hold their values until the next DONE; they are never partially updated.
- Reset mid-operation: aborts immediately and all outputs return to reset values.
  - The next accepted trigger starts a fresh run at channel 0.
- Zero operands still take the full latency; there is no early termination.

Decomposition:
- Package mul_pkg: FSM state enum (IDLE, MUL, STORE, DONE), function computing STEPS, and saturation-limit helper functions for signed/unsigned.
- Sub-module mul_core: single-channel iterative shift-add engine.
  - Inputs: load, operand magnitudes, sign.
  - Outputs: 2*C_WIDTH product and a step_done flag.
  - Parameterised by C_WIDTH and BITS_PER_CYCLE.
- multiplier_mc owns the FSM, channel mux, post-processing and result buffer.

Test Plan:
- Unsigned wrap (W=8, NUM_CH=2, BPC=1, FP=0, SIGNED=0, SATURATE=0).
  - Stimulus: a={0x24,0x03}, b={0x73,0x02} (ch1,ch0).
  - Expected: y={0x2C,0x06}, ovf=2'b10; done exactly 19 edges after trigger.
- Same with SATURATE=1 → y={0xFF,0x06}, ovf=2'b10.
- Signed Q3.4 (W=8, FP=4, SIGNED=1, SATURATE=1).
  - Stimulus: ch0 0x18×0xE0, ch1 0x7F×0x7F.
  - Expected: ch0=0xD0 (1.5×−2.0=−3.0), ovf0=0; ch1=0x7F, ovf1=1.
  - Also 0x80×0x80 at FP=0 → 0x7F, ovf=1.
- Handshake: pulse trigger again 3 cycles into a run with different operands.
  - Expected: ignored; results match the first operands; ready stays low until done falls; exactly one done pulse.
- Reset mid-run: assert reset at edge 7 of a run.
  - Expected: y=0, ovf=0, ready=1, done=0 immediately with no clock.
  - After release, a new trigger gives correct results at full latency.
- Throughput variant: BPC=4, W=8, NUM_CH=2.
  - Stimulus: same operands as the unsigned-wrap case.
  - Expected: identical y/ovf, with done after LAT=2*(2+1)+1=7 edges.
